// File: rtl/wb_regfile.sv
// Y86-64 writeback register file with halt tracking and retire counter.
// Define WB_BYPASS_EN to forward the value being committed to the read ports.
module wb_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  w_stat,
  input  logic [3:0]  w_icode,
  input  logic [3:0]  w_rA,
  input  logic [3:0]  w_rB,
  input  logic        w_cnd,
  input  logic [63:0] w_valE,
  input  logic [63:0] w_valM,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  output logic [63:0] d_rvalA,
  output logic [63:0] d_rvalB,
  output logic        halted,
  output logic [2:0]  stat_out,
  output logic [63:0] retired
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [3:0] RNONE    = 4'hF;
  localparam logic [3:0] RSP      = 4'h4;

  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OP    = 4'h6;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  logic [63:0] regs_q [15];
  logic [63:0] regs_d [15];
  logic        halted_q, halted_d;
  logic [2:0]  stat_q, stat_d;
  logic [63:0] retired_q, retired_d;

  logic [3:0]  dst_e, dst_m;
  logic        commit;

  always_comb begin
    dst_e = RNONE;
    unique case (1'b1)
      w_icode == I_CMOV:
        dst_e = w_cnd ? w_rB : RNONE;
      (w_icode == I_IRMOV) || (w_icode == I_OP):
        dst_e = w_rB;
      (w_icode == I_CALL) || (w_icode == I_RET) ||
      (w_icode == I_PUSH) || (w_icode == I_POP):
        dst_e = RSP;
      default:
        dst_e = RNONE;
    endcase
  end

  always_comb begin
    dst_m = RNONE;
    unique case (1'b1)
      (w_icode == I_MRMOV) || (w_icode == I_POP):
        dst_m = w_rA;
      default:
        dst_m = RNONE;
    endcase
  end

  assign commit = (w_stat == STAT_AOK) && !halted_q;

  // dstM is applied last so it wins when both target the same register
  always_comb begin
    halted_d  = halted_q;
    stat_d    = stat_q;
    retired_d = retired_q;
    for (int i = 0; i < 15; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (!halted_q) begin
      if (w_stat == STAT_AOK) begin
        retired_d = retired_q + 64'd1;
        for (int i = 0; i < 15; i++) begin
          if (dst_e == 4'(i)) regs_d[i] = w_valE;
          if (dst_m == 4'(i)) regs_d[i] = w_valM;
        end
      end else begin
        halted_d = 1'b1;
        stat_d   = w_stat;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) begin
        regs_q[i] <= '0;
      end
      halted_q  <= 1'b0;
      stat_q    <= STAT_AOK;
      retired_q <= '0;
    end else begin
      regs_q    <= regs_d;
      halted_q  <= halted_d;
      stat_q    <= stat_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    d_rvalA = '0;
    d_rvalB = '0;
    for (int i = 0; i < 15; i++) begin
      if (d_srcA == 4'(i)) d_rvalA = regs_q[i];
      if (d_srcB == 4'(i)) d_rvalB = regs_q[i];
    end
`ifdef WB_BYPASS_EN
    if (commit && !rst) begin
      if (dst_e != RNONE && d_srcA == dst_e) d_rvalA = w_valE;
      if (dst_e != RNONE && d_srcB == dst_e) d_rvalB = w_valE;
      if (dst_m != RNONE && d_srcA == dst_m) d_rvalA = w_valM;
      if (dst_m != RNONE && d_srcB == dst_m) d_rvalB = w_valM;
    end
`endif
  end

  assign halted   = halted_q;
  assign stat_out = stat_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: expected register contents are queued
// when an instruction is driven and read back after its commit edge.
`timescale 1ns/1ps
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  w_stat;
  logic [3:0]  w_icode, w_rA, w_rB;
  logic        w_cnd;
  logic [63:0] w_valE, w_valM;
  logic [3:0]  d_srcA, d_srcB;
  logic [63:0] d_rvalA, d_rvalB;
  logic        halted;
  logic [2:0]  stat_out;
  logic [63:0] retired;

  typedef struct {
    logic [3:0]  src;
    logic [63:0] val;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_ret;

  wb_regfile dut (
    .clk      (clk),
    .rst      (rst),
    .w_stat   (w_stat),
    .w_icode  (w_icode),
    .w_rA     (w_rA),
    .w_rB     (w_rB),
    .w_cnd    (w_cnd),
    .w_valE   (w_valE),
    .w_valM   (w_valM),
    .d_srcA   (d_srcA),
    .d_srcB   (d_srcB),
    .d_rvalA  (d_rvalA),
    .d_rvalB  (d_rvalB),
    .halted   (halted),
    .stat_out (stat_out),
    .retired  (retired)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [2:0] st, input logic [3:0] ic,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input logic cnd, input logic [63:0] ve,
                       input logic [63:0] vm);
    w_stat  = st;
    w_icode = ic;
    w_rA    = ra;
    w_rB    = rb;
    w_cnd   = cnd;
    w_valE  = ve;
    w_valM  = vm;
  endtask

  task automatic push(input logic [3:0] src, input logic [63:0] val);
    exp_t x;
    x.src = src;
    x.val = val;
    sb.push_back(x);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    d_srcA = 4'h0;
    d_srcB = 4'h0;
    drive(3'd1, 4'h3, 4'hF, 4'h7, 1'b0, 64'h77, 64'h0);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      d_srcA = 4'(i);
      d_srcB = 4'(15 - i);
      #1;
      checks++;
      if (d_rvalA !== 64'h0) begin
        errors++;
        $display("FAIL reset_read reg%0d got %h exp 0", i, d_rvalA);
      end
    end
    checks++;
    if (halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_halted got %b exp 0", halted);
    end
    checks++;
    if (stat_out !== 3'd1) begin
      errors++;
      $display("FAIL reset_stat got %0d exp 1", stat_out);
    end
    @(negedge clk);
    rst = 1'b0;
    d_srcA = 4'h7;
    #1;
    checks++;
    if (d_rvalA !== 64'h0) begin
      errors++;
      $display("FAIL reset_edge_ignored reg7 got %h exp 0", d_rvalA);
    end
    checks++;
    if (retired !== 64'h0) begin
      errors++;
      $display("FAIL reset_retired got %0d exp 0", retired);
    end
    exp_ret = 64'd0;
  endtask

  task automatic test_irmovq;
    drive(3'd1, 4'h3, 4'hF, 4'h2, 1'b0, 64'h55, 64'h0);
    push(4'h2, 64'h55);
    exp_ret++;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      d_srcA = e.src;
      #1;
      checks++;
      if (d_rvalA !== e.val) begin
        errors++;
        $display("FAIL irmovq reg%0d got %h exp %h", e.src, d_rvalA, e.val);
      end
    end
    checks++;
    if (retired !== exp_ret) begin
      errors++;
      $display("FAIL irmovq_retired got %0d exp %0d", retired, exp_ret);
    end
  endtask

  task automatic test_popq;
    drive(3'd1, 4'hB, 4'h4, 4'hF, 1'b0, 64'h100, 64'h200);
    push(4'h4, 64'h200);
    exp_ret++;
    @(negedge clk);
    drive(3'd1, 4'hB, 4'h1, 4'hF, 1'b0, 64'h108, 64'h33);
    push(4'h4, 64'h108);
    push(4'h1, 64'h33);
    exp_ret++;
    e = sb.pop_front();
    d_srcB = e.src;
    #1;
    checks++;
    if (d_rvalB !== e.val) begin
      errors++;
      $display("FAIL popq_rsp reg%0d got %h exp %h", e.src, d_rvalB, e.val);
    end
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      d_srcB = e.src;
      #1;
      checks++;
      if (d_rvalB !== e.val) begin
        errors++;
        $display("FAIL popq reg%0d got %h exp %h", e.src, d_rvalB, e.val);
      end
    end
    checks++;
    if (retired !== exp_ret) begin
      errors++;
      $display("FAIL popq_retired got %0d exp %0d", retired, exp_ret);
    end
  endtask

  task automatic test_cmov;
    drive(3'd1, 4'h2, 4'h1, 4'h3, 1'b0, 64'h7, 64'h0);
    push(4'h3, 64'h0);
    exp_ret++;
    @(negedge clk);
    e = sb.pop_front();
    d_srcA = e.src;
    #1;
    checks++;
    if (d_rvalA !== e.val) begin
      errors++;
      $display("FAIL cmov_nc reg%0d got %h exp %h", e.src, d_rvalA, e.val);
    end
    drive(3'd1, 4'h2, 4'h1, 4'h3, 1'b1, 64'h7, 64'h0);
    push(4'h3, 64'h7);
    exp_ret++;
    @(negedge clk);
    e = sb.pop_front();
    d_srcA = e.src;
    #1;
    checks++;
    if (d_rvalA !== e.val) begin
      errors++;
      $display("FAIL cmov_c reg%0d got %h exp %h", e.src, d_rvalA, e.val);
    end
    checks++;
    if (retired !== exp_ret) begin
      errors++;
      $display("FAIL cmov_retired got %0d exp %0d", retired, exp_ret);
    end
  endtask

  task automatic test_misc;
    drive(3'd1, 4'h5, 4'h8, 4'h9, 1'b0, 64'h1234, 64'hDEAD);
    push(4'h8, 64'hDEAD);
    push(4'h9, 64'h0);
    exp_ret++;
    @(negedge clk);
    drive(3'd1, 4'h8, 4'hF, 4'hF, 1'b0, 64'h3F8, 64'h0);
    push(4'h4, 64'h3F8);
    push(4'hF, 64'h0);
    exp_ret++;
    repeat (2) begin
      e = sb.pop_front();
      d_srcA = e.src;
      #1;
      checks++;
      if (d_rvalA !== e.val) begin
        errors++;
        $display("FAIL mrmovq reg%0d got %h exp %h", e.src, d_rvalA, e.val);
      end
    end
    @(negedge clk);
    drive(3'd1, 4'h1, 4'hF, 4'hF, 1'b0, 64'hFFFF, 64'hEEEE);
    push(4'h2, 64'h55);
    exp_ret++;
    repeat (2) begin
      e = sb.pop_front();
      d_srcA = e.src;
      #1;
      checks++;
      if (d_rvalA !== e.val) begin
        errors++;
        $display("FAIL call reg%0d got %h exp %h", e.src, d_rvalA, e.val);
      end
    end
    @(negedge clk);
    e = sb.pop_front();
    d_srcA = e.src;
    #1;
    checks++;
    if (d_rvalA !== e.val) begin
      errors++;
      $display("FAIL nop reg%0d got %h exp %h", e.src, d_rvalA, e.val);
    end
    checks++;
    if (retired !== exp_ret) begin
      errors++;
      $display("FAIL nop_retired got %0d exp %0d", retired, exp_ret);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++) begin
      drive(3'd1, 4'h6, 4'h1, 4'(10 + i), 1'b0, 64'(i + 1), 64'h0);
      push(4'(10 + i), 64'(i + 1));
      exp_ret++;
      @(negedge clk);
    end
    drive(3'd1, 4'h6, 4'h1, 4'hF, 1'b0, 64'h0, 64'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      d_srcB = e.src;
      #1;
      checks++;
      if (d_rvalB !== e.val) begin
        errors++;
        $display("FAIL b2b reg%0d got %h exp %h", e.src, d_rvalB, e.val);
      end
    end
    checks++;
    if (retired !== exp_ret) begin
      errors++;
      $display("FAIL b2b_retired got %0d exp %0d", retired, exp_ret);
    end
    @(negedge clk);
    exp_ret++;
  endtask

  task automatic test_bypass;
    logic [63:0] want;
    drive(3'd1, 4'h3, 4'hF, 4'h6, 1'b0, 64'hAB, 64'h0);
    d_srcB = 4'h6;
`ifdef WB_BYPASS_EN
    want = 64'hAB;
`else
    want = 64'h0;
`endif
    #1;
    checks++;
    if (d_rvalB !== want) begin
      errors++;
      $display("FAIL bypass_e got %h exp %h", d_rvalB, want);
    end
    push(4'h6, 64'hAB);
    exp_ret++;
    @(negedge clk);
    e = sb.pop_front();
    d_srcB = e.src;
    drive(3'd1, 4'hB, 4'h4, 4'hF, 1'b0, 64'h500, 64'h600);
    d_srcA = 4'h4;
`ifdef WB_BYPASS_EN
    want = 64'h600;
`else
    want = 64'h3F8;
`endif
    #1;
    checks++;
    if (d_rvalB !== e.val) begin
      errors++;
      $display("FAIL bypass_after reg%0d got %h exp %h", e.src, d_rvalB, e.val);
    end
    checks++;
    if (d_rvalA !== want) begin
      errors++;
      $display("FAIL bypass_m got %h exp %h", d_rvalA, want);
    end
    push(4'h4, 64'h600);
    exp_ret++;
    @(negedge clk);
    e = sb.pop_front();
    d_srcA = e.src;
    #1;
    checks++;
    if (d_rvalA !== e.val) begin
      errors++;
      $display("FAIL bypass_m_after reg%0d got %h exp %h", e.src, d_rvalA, e.val);
    end
  endtask

  task automatic test_halt;
    drive(3'd2, 4'h6, 4'h1, 4'h5, 1'b0, 64'h9, 64'h0);
    push(4'h5, 64'h0);
    @(negedge clk);
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_flag got %b exp 1", halted);
    end
    checks++;
    if (stat_out !== 3'd2) begin
      errors++;
      $display("FAIL halt_stat got %0d exp 2", stat_out);
    end
    checks++;
    if (retired !== exp_ret) begin
      errors++;
      $display("FAIL halt_retired got %0d exp %0d", retired, exp_ret);
    end
    e = sb.pop_front();
    d_srcA = e.src;
    #1;
    checks++;
    if (d_rvalA !== e.val) begin
      errors++;
      $display("FAIL halt_suppress reg%0d got %h exp %h", e.src, d_rvalA, e.val);
    end
    drive(3'd1, 4'h3, 4'hF, 4'h5, 1'b0, 64'h99, 64'h0);
    repeat (3) @(negedge clk);
    drive(3'd3, 4'hB, 4'h2, 4'hF, 1'b0, 64'h1, 64'h2);
    push(4'h5, 64'h0);
    push(4'h2, 64'h55);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      d_srcA = e.src;
      #1;
      checks++;
      if (d_rvalA !== e.val) begin
        errors++;
        $display("FAIL frozen reg%0d got %h exp %h", e.src, d_rvalA, e.val);
      end
    end
    checks++;
    if (halted !== 1'b1 || stat_out !== 3'd2) begin
      errors++;
      $display("FAIL frozen_stat got %b/%0d exp 1/2", halted, stat_out);
    end
    checks++;
    if (retired !== exp_ret) begin
      errors++;
      $display("FAIL frozen_retired got %0d exp %0d", retired, exp_ret);
    end
  endtask

  task automatic test_async_reset;
    d_srcA = 4'h2;
    d_srcB = 4'h6;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (d_rvalA !== 64'h0 || d_rvalB !== 64'h0) begin
      errors++;
      $display("FAIL areset_regs got %h/%h exp 0/0", d_rvalA, d_rvalB);
    end
    checks++;
    if (halted !== 1'b0 || stat_out !== 3'd1) begin
      errors++;
      $display("FAIL areset_stat got %b/%0d exp 0/1", halted, stat_out);
    end
    checks++;
    if (retired !== 64'h0) begin
      errors++;
      $display("FAIL areset_retired got %0d exp 0", retired);
    end
    sb.delete();
    exp_ret = 64'd0;
    @(negedge clk);
  endtask

  task automatic test_bad_stat;
    logic [2:0] bad [2];
    bad[0] = 3'd0;
    bad[1] = 3'd7;
    for (int k = 0; k < 2; k++) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      drive(bad[k], 4'h3, 4'hF, 4'h2, 1'b0, 64'h5, 64'h0);
      push(4'h2, 64'h0);
      @(negedge clk);
      e = sb.pop_front();
      d_srcA = e.src;
      #1;
      checks++;
      if (d_rvalA !== e.val) begin
        errors++;
        $display("FAIL badstat reg%0d got %h exp %h", e.src, d_rvalA, e.val);
      end
      checks++;
      if (halted !== 1'b1 || stat_out !== bad[k]) begin
        errors++;
        $display("FAIL badstat_latch got %b/%0d exp 1/%0d",
                 halted, stat_out, bad[k]);
      end
      checks++;
      if (retired !== 64'h0) begin
        errors++;
        $display("FAIL badstat_retired got %0d exp 0", retired);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_irmovq();
    test_popq();
    test_cmov();
    test_misc();
    test_back_to_back();
    test_bypass();
    test_halt();
    test_async_reset();
    test_bad_stat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have ports: clk input 1, system clock; all state updates on posedge clk.
REQ-002 SHALL have rst input 1, reset; asynchronous, active-high.
REQ-003 SHALL have w_stat input 3, writeback-stage status (AOK=1, HLT=2, ADR=3, INS=4).
REQ-004 SHALL have w_icode input 4, writeback-stage instruction code (Y86-64 encoding).
REQ-005 SHALL have w_rA, w_rB input 4 each, register specifiers (0xF = none).
REQ-006 SHALL have w_cnd input 1, condition result for cmovXX.
REQ-007 SHALL have w_valE, w_valM input 64 each, ALU and memory results.
REQ-008 SHALL have d_srcA, d_srcB input 4 each, decode-stage read addresses.
REQ-009 SHALL have d_rvalA, d_rvalB output 64 each, combinational read data.
REQ-010 SHALL have halted output 1, sticky stop flag.
REQ-011 SHALL have stat_out output 3, architectural status.
REQ-012 SHALL have retired output 64, count of committed instructions.

Function
REQ-013 SHALL hold 15 registers of 64 bits, indices 0..14; index 0xF is never written and reads 0.
REQ-014 SHALL derive dstE: rB for rrmovq/cmovXX (icode 2) when w_cnd=1, else 0xF; rB for irmovq (3) and OPq (6); 4 (%rsp) for call (8), ret (9), pushq (A), popq (B); 0xF otherwise.
REQ-015 SHALL derive dstM: rA for mrmovq (5) and popq (B); 0xF otherwise.
REQ-016 SHALL write valE to dstE and valM to dstM on the same posedge, only when w_stat=AOK and halted=0.
REQ-017 SHALL give dstM priority when dstE equals dstM (popq %rsp writes valM).
REQ-018 SHALL make all writes visible to reads one cycle after the commit edge.
REQ-019 SHALL set halted=1 and latch stat_out=w_stat on the first posedge with halted=0 and w_stat not AOK; register writes SHALL be suppressed on that edge.
REQ-020 SHALL keep halted, stat_out, registers and retired frozen while halted=1, regardless of inputs.
REQ-021 SHALL increment retired by 1 on each posedge with w_stat=AOK and halted=0, including nop; SHALL wrap from 2^64-1 to 0.
REQ-022 SHALL treat w_stat values outside 1..4 as non-AOK (halt with that value latched).

Reset
REQ-023 SHALL, while rst=1, force all 15 registers to 0, halted=0, stat_out=AOK and retired=0, independent of clk.
REQ-024 SHALL ignore an instruction present at the posedge on which rst is asserted; first commit occurs on the first posedge after rst deasserts.
REQ-025 SHALL keep d_rvalA/d_rvalB combinational from register contents during reset (reading 0).

Configuration
REQ-026 SHALL, with WB_BYPASS_EN defined, return the value being committed this cycle on d_rvalA/d_rvalB when d_srcX matches an active dstM (priority) or dstE of a write enabled per REQ-016.
REQ-027 SHALL, without WB_BYPASS_EN, return only stored register contents (REQ-018 timing).

Verification
REQ-028 Reset then irmovq (icode 3, rB=2, valE=0x55), AOK -> next cycle d_srcA=2 gives 0x55; retired=1.
REQ-029 popq with rA=4, valE=0x100, valM=0x200 -> %rsp=0x200 after edge; retired increments.
REQ-030 cmovXX rA=1, rB=3, valE=0x7, w_cnd=0 -> reg 3 unchanged (0); w_cnd=1 repeated -> reg 3=0x7.
REQ-031 w_stat=HLT with OPq rB=5, valE=0x9 -> reg 5 stays 0, halted=1, stat_out=2, retired frozen; later AOK inputs ignored until rst.
REQ-032 WB_BYPASS_EN defined: irmovq rB=6 valE=0xAB with d_srcB=6 same cycle -> d_rvalB=0xAB before edge; undefined -> old value 0 before edge, 0xAB after.
REQ-033 Assert rst mid-sequence after regs loaded -> all reads 0, halted=0, stat_out=1, retired=0 immediately, without a clock edge.
